logic_unit_sequencer: RTL and testbench

//  Bit-serial controller that shares one 1-bit logic cell (OR/NOR/XOR/XNOR) between two requesters.
//  - Arbitrates two operand ports round-robin.
//  - Latches the granted W-bit operands and op, then feeds one bit pair per cycle through the cell, LSB first.
//  - Assembles the W-bit result and returns it on a valid/ready result port, tagged with the requester id.
//  - Sits between the guide-level test harness and the shared logic cell.

---
 rtl/logic_seq_pkg.sv | 16 +
 rtl/logic_bit_cell.sv | 23 ++
 rtl/logic_unit_sequencer.sv | 145 ++++++++++++++
 tb/tb_logic_unit_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_seq_pkg.sv
// Shared op codes and FSM state encodings for the
// bit-serial logic sequencer.
package logic_seq_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/logic_bit_cell.sv
// One-bit shared logic cell: OR, NOR, XOR, XNOR.
// Purely combinational; the only op decoder in the design.
module logic_bit_cell
  import logic_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    unique case (op)
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_unit_sequencer.sv
// Round-robin arbiter and FSM that streams W-bit operands
// LSB first through one shared logic_bit_cell.
module logic_unit_sequencer
  import logic_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

  state_e           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic [W-1:0]     res_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_valid_q;
  logic             res_id_q;
  logic             last_q;

  logic             idle;
  logic             gnt_id;
  logic             accept;
  logic             cell_y;
  logic             cnt_bad;
  logic [31:0]      cnt_ext;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic [1:0]       op_in;

  // On contention, grant whoever was not served last.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = req1_valid;
    end
  end

  assign idle       = (state_q == ST_IDLE);
  assign req0_ready = idle & req0_valid & ~gnt_id;
  assign req1_ready = idle & req1_valid & gnt_id;
  assign accept     = req0_ready | req1_ready;

  assign a_in  = gnt_id ? req1_a  : req0_a;
  assign b_in  = gnt_id ? req1_b  : req0_b;
  assign op_in = gnt_id ? req1_op : req0_op;

  assign cnt_ext = 32'(cnt_q);
  assign cnt_bad = cnt_ext > 32'(W - 1);

  logic_bit_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .op (op_q),
    .y  (cell_y)
  );

  // New bit enters at the MSB; after W shifts bit 0 lands at LSB.
  always_comb begin
    res_d        = res_q >> 1;
    res_d[W-1]   = cell_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_OR;
      res_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q      <= a_in;
            b_q      <= b_in;
            op_q     <= op_in;
            res_id_q <= gnt_id;
            cnt_q    <= '0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_bad) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_d;
            if (cnt_q == CNT_MAX) begin
              cnt_q       <= '0;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            last_q      <= res_id_q;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Directed self-checking bench for logic_unit_sequencer
// at W=8 with hand-computed results.
module tb_logic_unit_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_sequencer #(.W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
  );

  // Stimulus driver: one request, then wait and handshake the result.
  task automatic run_op(input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] op,
                        output logic [7:0] data, output logic rid,
                        output int lat, output logic acc);
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end
    @(negedge clk);
    acc = id ? req1_ready : req0_ready;
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    data = res_data;
    rid  = res_id;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    req0_valid = 1;
    req1_valid = 1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", res_valid);
    end
    total++;
    if (res_data !== 8'h00) begin
      bad++; $display("FAIL rst_data got=%h exp=00", res_data);
    end
    total++;
    if (res_id !== 1'b0) begin
      bad++; $display("FAIL rst_id got=%b exp=0", res_id);
    end
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pref got=%b%b exp=10", req0_ready, req1_ready);
    end
    req0_valid = 0;
    req1_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] d; logic id; int lat; logic acc;
    run_op(1'b0, 8'hA5, 8'h0F, 2'b00, d, id, lat, acc);
    total++;
    if (acc !== 1'b1) begin
      bad++; $display("FAIL basic_acc got=%b exp=1", acc);
    end
    total++;
    if (d !== 8'hAF) begin
      bad++; $display("FAIL basic_or got=%h exp=af", d);
    end
    total++;
    if (id !== 1'b0) begin
      bad++; $display("FAIL basic_id got=%b exp=0", id);
    end
    total++;
    if (lat != 8) begin
      bad++; $display("FAIL basic_lat got=%0d exp=8", lat);
    end
  endtask

  task automatic test_ops;
    logic [7:0] d; logic id; int lat; logic acc;
    logic [7:0] exp_tab [3] = '{8'h50, 8'hAA, 8'h55};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 8'hA5, 8'h0F, 2'(i + 1), d, id, lat, acc);
      total++;
      if (d !== exp_tab[i] || lat != 8) begin
        bad++;
        $display("FAIL op%0d got=%h/%0d exp=%h/8",
                 i + 1, d, lat, exp_tab[i]);
      end
    end
  endtask

  task automatic test_round_robin;
    int grants[$];
    int ids[$];
    logic [7:0] datas[$];
    int both = 0;
    int lat;
    reset = 1;
    @(posedge clk); #1 reset = 0;
    req0_a = 8'hF0; req0_b = 8'h0F; req0_op = 2'b10;
    req1_a = 8'hFF; req1_b = 8'hFF; req1_op = 2'b10;
    req0_valid = 1;
    req1_valid = 1;
    res_ready = 1;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both++;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (res_valid && res_ready) begin
        ids.push_back(int'(res_id));
        datas.push_back(res_data);
      end
      @(posedge clk); #1;
    end
    req0_valid = 0;
    req1_valid = 0;
    wait_res(lat);
    @(posedge clk); #1;
    res_ready = 0;
    total++;
    if (both != 0) begin
      bad++; $display("FAIL rr_both got=%0d exp=0", both);
    end
    total++;
    if (grants.size() < 4 || ids.size() != 4) begin
      bad++;
      $display("FAIL rr_count got=%0d/%0d exp>=4/4",
               grants.size(), ids.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size() && i < ids.size()) begin
        total++;
        if (grants[i] != i % 2 || ids[i] != i % 2 ||
            datas[i] !== ((i % 2) ? 8'h00 : 8'hFF)) begin
          bad++;
          $display("FAIL rr_%0d got=g%0d i%0d d%h exp=%0d",
                   i, grants[i], ids[i], datas[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    req0_valid = 1;
    req0_a = 8'hA5; req0_b = 8'h0F; req0_op = 2'b00;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL stall_acc got=%b exp=1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1;
    req1_a = 8'h33; req1_b = 8'h0F; req1_op = 2'b00;
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== 8'hAF ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d got=v%b d%h r%b%b exp=v1 daf r00",
                 i, res_valid, res_data, req0_ready, req1_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_rel got=v%b r1%b exp=v0 r11",
               res_valid, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    wait_res(lat);
    total++;
    if (res_data !== 8'h3F || res_id !== 1'b1 || lat != 8) begin
      bad++;
      $display("FAIL stall_next got=%h/%b/%0d exp=3f/1/8",
               res_data, res_id, lat);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic id; int lat; logic acc;
    run_op(1'b0, 8'h12, 8'h34, 2'b10, d, id, lat, acc);
    total++;
    if (d !== 8'h26 || id !== 1'b0) begin
      bad++; $display("FAIL rmid_pre got=%h/%b exp=26/0", d, id);
    end
    req1_valid = 1;
    req1_a = 8'hFF; req1_b = 8'h00; req1_op = 2'b11;
    @(negedge clk);
    @(posedge clk); #1;
    req1_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    req0_valid = 1; req0_a = 8'hC3; req0_b = 8'h5A; req0_op = 2'b00;
    req1_valid = 1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || res_data !== 8'h00) begin
      bad++;
      $display("FAIL rmid_clr got=v%b d%h exp=v0 d00",
               res_valid, res_data);
    end
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_pref got=%b%b exp=10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    wait_res(lat);
    total++;
    if (res_data !== 8'hDB || res_id !== 1'b0 || lat != 8) begin
      bad++;
      $display("FAIL rmid_op got=%h/%b/%0d exp=db/0/8",
               res_data, res_id, lat);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic test_input_change;
    int lat = 0;
    req0_valid = 1;
    req0_a = 8'h3C; req0_b = 8'hC3; req0_op = 2'b10;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL chg_acc got=%b exp=1", req0_ready);
    end
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      req0_a  = 8'($urandom);
      req0_b  = 8'($urandom);
      req0_op = 2'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    total++;
    if (res_data !== 8'hFF || res_id !== 1'b0 || lat != 8) begin
      bad++;
      $display("FAIL chg_res got=%h/%b/%0d exp=ff/0/8",
               res_data, res_id, lat);
    end
    req0_valid = 0;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    reset = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    res_ready = 0;
    test_reset;
    test_basic;
    test_ops;
    test_round_robin;
    test_stall;
    test_reset_mid;
    test_input_change;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
